// File: rtl/lsu_mem_initiator_if.sv
// Bundle of the request, memory-port and response signals of the load/store initiator.
//
// master : the initiator side (accepts requests, drives the memory port, returns responses)
// slave  : the environment side (pipeline MEM stage plus data memory)
//
// Signals
//   req_valid_i/req_ready_o  request handshake
//   req_we_i, req_funct3_i   store flag and RV32I funct3
//   req_addr_i, req_wdata_i  byte address and right-justified store data
//   mem_addr_o               word-aligned memory address
//   mem_data_o, mem_strb_o   lane-shifted write data and byte strobes
//   mem_read_en_o/mem_write_en_o  access enables
//   mem_data_i, mem_data_vld_i    combinational read data and its valid flag
//   rsp_valid_o, rsp_rdata_o, rsp_err_o  one-cycle response
interface lsu_mem_initiator_if #(
    parameter int unsigned AWIDTH = 32,
    parameter int unsigned DWIDTH = 32
) ();
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_we_i;
    logic [2:0]            req_funct3_i;
    logic [AWIDTH-1:0]     req_addr_i;
    logic [DWIDTH-1:0]     req_wdata_i;

    logic [AWIDTH-1:0]     mem_addr_o;
    logic [DWIDTH-1:0]     mem_data_o;
    logic [DWIDTH/8-1:0]   mem_strb_o;
    logic                  mem_read_en_o;
    logic                  mem_write_en_o;
    logic [DWIDTH-1:0]     mem_data_i;
    logic                  mem_data_vld_i;

    logic                  rsp_valid_o;
    logic [DWIDTH-1:0]     rsp_rdata_o;
    logic                  rsp_err_o;

    modport master (
        input  req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i,
        input  mem_data_i, mem_data_vld_i,
        output req_ready_o,
        output mem_addr_o, mem_data_o, mem_strb_o, mem_read_en_o, mem_write_en_o,
        output rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

    modport slave (
        output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i,
        output mem_data_i, mem_data_vld_i,
        input  req_ready_o,
        input  mem_addr_o, mem_data_o, mem_strb_o, mem_read_en_o, mem_write_en_o,
        input  rsp_valid_o, rsp_rdata_o, rsp_err_o
    );
endinterface

// File: rtl/lsu_mem_initiator.sv
// Load/store initiator for the MEM stage.
//
// Accepts one RV32I load/store at a time, drives word-aligned accesses with byte strobes and
// lane-shifted store data, and returns a one-cycle response with extended load data and an
// error flag. Word-crossing accesses are split into two sequential word accesses when
// ALLOW_MISALIGNED is set; otherwise any misaligned half/word request errors without touching
// memory. Only DWIDTH = 32 (four byte lanes) is supported.
//
// Ports
//   clk  clock
//   rst  asynchronous active-high reset
//   bus  lsu_mem_initiator_if.master (request, memory port, response)
module lsu_mem_initiator #(
    parameter int unsigned AWIDTH           = 32,
    parameter int unsigned DWIDTH           = 32,
    parameter bit          ALLOW_MISALIGNED = 1'b1
) (
    input logic                 clk,
    input logic                 rst,
    lsu_mem_initiator_if.master bus
);

    typedef enum logic [1:0] {StIdle, StAcc0, StAcc1, StResp} state_e;

    // Access size in bytes from funct3[1:0]; the 2'b11 encoding is rejected as illegal earlier.
    function automatic logic [2:0] size_of(input logic [1:0] sz);
        case (sz)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we) begin
            return f3 inside {3'b000, 3'b001, 3'b010};
        end
        return f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    endfunction

    state_e              state_q, state_d;
    logic                we_q, we_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [AWIDTH-1:0]   addr_q, addr_d;
    logic [DWIDTH-1:0]   wdata_q, wdata_d;
    logic [DWIDTH-1:0]   lo_q, lo_d;
    logic [DWIDTH-1:0]   hi_q, hi_d;
    logic                err_q, err_d;

    // Request decode (only meaningful while idle)
    logic [1:0]          req_off;
    logic                req_misal;
    logic                req_err;

    assign req_off   = bus.req_addr_i[1:0];
    assign req_misal = ((bus.req_funct3_i[1:0] == 2'b01) && req_off[0]) ||
                       ((bus.req_funct3_i[1:0] == 2'b10) && (req_off != 2'b00));
    assign req_err   = !f3_legal(bus.req_we_i, bus.req_funct3_i) ||
                       (req_misal && !ALLOW_MISALIGNED);

    // Latched-request derived values
    logic [1:0]          off;
    logic [2:0]          size;
    logic                span;
    logic [AWIDTH-1:0]   aligned;
    logic [7:0]          mask8;
    logic [DWIDTH-1:0]   wd_masked;
    logic [2*DWIDTH-1:0] wd64;
    logic [DWIDTH-1:0]   ld_word;
    logic [DWIDTH-1:0]   ld_ext;

    assign off     = addr_q[1:0];
    assign size    = size_of(funct3_q[1:0]);
    assign span    = ({2'b00, off} + {1'b0, size}) > 4'd4;
    assign aligned = {addr_q[AWIDTH-1:2], 2'b00};

    always_comb begin
        unique case (funct3_q[1:0])
            2'b00:   mask8 = 8'h01;
            2'b01:   mask8 = 8'h03;
            default: mask8 = 8'h0f;
        endcase
        mask8 = mask8 << off;
    end

    always_comb begin
        unique case (funct3_q[1:0])
            2'b00:   wd_masked = {24'b0, wdata_q[7:0]};
            2'b01:   wd_masked = {16'b0, wdata_q[15:0]};
            default: wd_masked = wdata_q;
        endcase
    end

    // Lanes beyond byte 3 spill into the second word of a split store.
    assign wd64    = {{DWIDTH{1'b0}}, wd_masked} << {off, 3'b000};

    // hi_q is cleared on accept, so a non-split load shifts in zeros from above.
    assign ld_word = DWIDTH'({hi_q, lo_q} >> {off, 3'b000});

    always_comb begin
        case (funct3_q)
            3'b000:  ld_ext = {{24{ld_word[7]}}, ld_word[7:0]};
            3'b001:  ld_ext = {{16{ld_word[15]}}, ld_word[15:0]};
            3'b010:  ld_ext = ld_word;
            3'b100:  ld_ext = {24'b0, ld_word[7:0]};
            3'b101:  ld_ext = {16'b0, ld_word[15:0]};
            default: ld_ext = '0;
        endcase
    end

    // Next-state and request/data capture
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        err_d    = err_q;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid_i) begin
                    we_d     = bus.req_we_i;
                    funct3_d = bus.req_funct3_i;
                    addr_d   = bus.req_addr_i;
                    wdata_d  = bus.req_wdata_i;
                    lo_d     = '0;
                    hi_d     = '0;
                    err_d    = req_err;
                    state_d  = req_err ? StResp : StAcc0;
                end
            end
            StAcc0: begin
                if (!we_q) begin
                    lo_d  = bus.mem_data_i;
                    err_d = err_q | !bus.mem_data_vld_i;
                end
                state_d = span ? StAcc1 : StResp;
            end
            StAcc1: begin
                if (!we_q) begin
                    hi_d  = bus.mem_data_i;
                    err_d = err_q | !bus.mem_data_vld_i;
                end
                state_d = StResp;
            end
            StResp: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            we_q     <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            err_q    <= err_d;
        end
    end

    // Memory port: everything is zero outside the access states, so reset clears it at once.
    logic [AWIDTH-1:0]   mem_addr;
    logic [DWIDTH-1:0]   mem_data;
    logic [DWIDTH/8-1:0] mem_strb;
    logic                mem_re;
    logic                mem_we;

    always_comb begin
        mem_addr = '0;
        mem_data = '0;
        mem_strb = '0;
        mem_re   = 1'b0;
        mem_we   = 1'b0;
        unique case (state_q)
            StAcc0: begin
                mem_addr = aligned;
                if (we_q) begin
                    mem_we   = 1'b1;
                    mem_strb = mask8[3:0];
                    mem_data = wd64[DWIDTH-1:0];
                end else begin
                    mem_re = 1'b1;
                end
            end
            StAcc1: begin
                mem_addr = aligned + AWIDTH'(4);
                if (we_q) begin
                    mem_we   = 1'b1;
                    mem_strb = mask8[7:4];
                    mem_data = wd64[2*DWIDTH-1:DWIDTH];
                end else begin
                    mem_re = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.mem_addr_o     = mem_addr;
    assign bus.mem_data_o     = mem_data;
    assign bus.mem_strb_o     = mem_strb;
    assign bus.mem_read_en_o  = mem_re;
    assign bus.mem_write_en_o = mem_we;

    assign bus.req_ready_o = (state_q == StIdle) && !rst;
    assign bus.rsp_valid_o = (state_q == StResp);
    assign bus.rsp_err_o   = (state_q == StResp) && err_q;
    assign bus.rsp_rdata_o = ((state_q == StResp) && !we_q && !err_q) ? ld_ext : '0;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
module tb_lsu_mem_initiator;

    localparam logic [31:0] BASE = 32'h0100_0000;

    typedef struct packed {
        logic        ready;
        logic        re;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
        logic        rv;
        logic        rerr;
        logic [31:0] rdata;
    } cyc_t;

    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
        logic [1:0]  nacc;
        logic [31:0] addr0;
        logic [31:0] addr1;
        logic [3:0]  strb0;
        logic [3:0]  strb1;
        logic [31:0] data0;
        logic [31:0] data1;
        logic        we;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic mem_init;

    always #5 clk = ~clk;

    lsu_mem_initiator_if #(.AWIDTH(32), .DWIDTH(32)) if0 ();
    lsu_mem_initiator_if #(.AWIDTH(32), .DWIDTH(32)) if1 ();

    lsu_mem_initiator #(.AWIDTH(32), .DWIDTH(32), .ALLOW_MISALIGNED(1'b0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    lsu_mem_initiator #(.AWIDTH(32), .DWIDTH(32), .ALLOW_MISALIGNED(1'b1)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    logic [7:0] busmem [256];
    logic [7:0] refmem [256];
    cyc_t       q0[$];
    cyc_t       q1[$];
    int         checks = 0;
    int         errors = 0;

    function automatic bit inrange(logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'd256);
    endfunction

    function automatic logic [31:0] pat(logic [31:0] w);
        return {w[15:0], w[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    function automatic logic [7:0] init_byte(int i);
        return 8'((i * 37 + 11) & 255);
    endfunction

    // DUT0 memory: read-only pattern; DUT1 memory: byte array with strobed writes
    always_comb begin
        if0.mem_data_vld_i = inrange(if0.mem_addr_o);
        if0.mem_data_i     = pat(if0.mem_addr_o);
        if1.mem_data_vld_i = inrange(if1.mem_addr_o);
        if1.mem_data_i     = inrange(if1.mem_addr_o) ?
            {busmem[{if1.mem_addr_o[7:2], 2'd3}], busmem[{if1.mem_addr_o[7:2], 2'd2}],
             busmem[{if1.mem_addr_o[7:2], 2'd1}], busmem[{if1.mem_addr_o[7:2], 2'd0}]} :
            32'hBAD0_BAD0;
    end

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) busmem[i] <= init_byte(i);
        end else if (if1.mem_write_en_o && inrange(if1.mem_addr_o)) begin
            for (int l = 0; l < 4; l++) begin
                if (if1.mem_strb_o[l]) busmem[{if1.mem_addr_o[7:2], 2'(l)}] <= if1.mem_data_o[8*l +: 8];
            end
        end
    end

    // ---------------- behavioural model ----------------
    function automatic int size_of(logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic [7:0] rd_byte(int id, logic [31:0] a);
        logic [31:0] w;
        if (id == 0) begin
            w = pat(a & ~32'd3);
            return w[8*int'(a[1:0]) +: 8];
        end
        return refmem[a[7:0]];
    endfunction

    function automatic exp_t model(int id, bit allow, bit we, logic [2:0] f3,
                                   logic [31:0] addr, logic [31:0] wdata);
        exp_t        e;
        int          size;
        bit          legal;
        logic [31:0] w0;
        logic [31:0] ba;
        logic [31:0] val;
        int          lane;
        e    = '0;
        e.we = we;
        size = size_of(f3);
        legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal || (!allow && (addr % 32'(size)) != 0)) begin
            e.err = 1'b1;
            return e;
        end
        w0      = addr & ~32'd3;
        e.addr0 = w0;
        e.addr1 = w0 + 32'd4;
        e.nacc  = (((addr + 32'(size - 1)) & ~32'd3) != w0) ? 2'd2 : 2'd1;
        if (we) begin
            for (int i = 0; i < size; i++) begin
                ba   = addr + 32'(i);
                lane = int'(ba % 4);
                if ((ba & ~32'd3) == w0) begin
                    e.strb0[lane]          = 1'b1;
                    e.data0[8*lane +: 8]   = wdata[8*i +: 8];
                end else begin
                    e.strb1[lane]          = 1'b1;
                    e.data1[8*lane +: 8]   = wdata[8*i +: 8];
                end
            end
        end else begin
            e.err = !inrange(e.addr0) || (e.nacc == 2'd2 && !inrange(e.addr1));
            if (!e.err) begin
                val = '0;
                for (int i = 0; i < size; i++) val[8*i +: 8] = rd_byte(id, addr + 32'(i));
                if (!f3[2] && size == 1 && val[7])  val[31:8]  = '1;
                if (!f3[2] && size == 2 && val[15]) val[31:16] = '1;
                e.rdata = val;
            end
        end
        return e;
    endfunction

    task automatic apply_store(logic [2:0] f3, logic [31:0] a, logic [31:0] d);
        logic [31:0] ba;
        for (int i = 0; i < size_of(f3); i++) begin
            ba = a + 32'(i);
            if (inrange(ba)) refmem[ba[7:0]] = d[8*i +: 8];
        end
    endtask

    // Expected per-cycle outputs from the request cycle through the response cycle
    task automatic push_txn(int id, exp_t e, int limit);
        cyc_t c;
        cyc_t lst[$];
        c = '0;
        c.ready = 1'b1;
        lst.push_back(c);
        for (int k = 0; k < int'(e.nacc); k++) begin
            c = '0;
            c.addr = (k == 0) ? e.addr0 : e.addr1;
            if (e.we) begin
                c.we   = 1'b1;
                c.strb = (k == 0) ? e.strb0 : e.strb1;
                c.data = (k == 0) ? e.data0 : e.data1;
            end else begin
                c.re = 1'b1;
            end
            lst.push_back(c);
        end
        c       = '0;
        c.rv    = 1'b1;
        c.rerr  = e.err;
        c.rdata = e.rdata;
        lst.push_back(c);
        for (int i = 0; i < lst.size(); i++) begin
            if (limit == 0 || i < limit) begin
                if (id == 0) q0.push_back(lst[i]);
                else q1.push_back(lst[i]);
            end
        end
    endtask

    // ---------------- compare process ----------------
    cyc_t act0, act1;
    always_comb begin
        act0 = {if0.req_ready_o, if0.mem_read_en_o, if0.mem_write_en_o, if0.mem_addr_o,
                if0.mem_strb_o, if0.mem_data_o, if0.rsp_valid_o, if0.rsp_err_o, if0.rsp_rdata_o};
        act1 = {if1.req_ready_o, if1.mem_read_en_o, if1.mem_write_en_o, if1.mem_addr_o,
                if1.mem_strb_o, if1.mem_data_o, if1.rsp_valid_o, if1.rsp_err_o, if1.rsp_rdata_o};
    end

    always @(negedge clk) begin
        cyc_t act;
        cyc_t exp;
        for (int id = 0; id < 2; id++) begin
            act = (id == 0) ? act0 : act1;
            exp = '0;
            if (rst) begin
                act.ready = 1'b0;  // readiness during reset is not defined
            end else if (id == 0 && q0.size() > 0) begin
                exp = q0.pop_front();
            end else if (id == 1 && q1.size() > 0) begin
                exp = q1.pop_front();
            end else begin
                exp.ready = 1'b1;
            end
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL dut%0d cycle @%0t: got rdy=%b re=%b we=%b addr=%h strb=%h data=%h rv=%b err=%b rdata=%h | want rdy=%b re=%b we=%b addr=%h strb=%h data=%h rv=%b err=%b rdata=%h",
                         id, $time, act.ready, act.re, act.we, act.addr, act.strb, act.data,
                         act.rv, act.rerr, act.rdata, exp.ready, exp.re, exp.we, exp.addr,
                         exp.strb, exp.data, exp.rv, exp.rerr, exp.rdata);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic drive(int id, logic v, logic we, logic [2:0] f3, logic [31:0] a,
                         logic [31:0] d);
        if (id == 0) begin
            if0.req_valid_i = v; if0.req_we_i = we; if0.req_funct3_i = f3;
            if0.req_addr_i = a;  if0.req_wdata_i = d;
        end else begin
            if1.req_valid_i = v; if1.req_we_i = we; if1.req_funct3_i = f3;
            if1.req_addr_i = a;  if1.req_wdata_i = d;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called one time unit after a clock edge with the DUT idle; returns idle likewise.
    task automatic run_txn(int id, bit we, logic [2:0] f3, logic [31:0] addr,
                           logic [31:0] wdata, output exp_t e);
        e = model(id, id == 1, we, f3, addr, wdata);
        if (id == 1 && we && !e.err) apply_store(f3, addr, wdata);
        push_txn(id, e, 0);
        drive(id, 1'b1, we, f3, addr, wdata);
        step();
        drive(id, 1'b0, 1'($urandom), 3'($urandom), $urandom, $urandom);
        repeat (int'(e.nacc) + 1) step();
    endtask

    task automatic rand_txn(int id);
        exp_t        e;
        logic [31:0] a;
        if ($urandom_range(0, 7) == 0) a = $urandom;
        else a = BASE + 32'($urandom_range(0, 255));
        run_txn(id, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, e);
        repeat ($urandom_range(0, 2)) step();
    endtask

    initial begin
        exp_t e;
        rst      = 1'b1;
        mem_init = 1'b1;
        drive(0, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 3'b0, 32'h0, 32'h0);
        for (int i = 0; i < 256; i++) refmem[i] = init_byte(i);
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b0;
        mem_init = 1'b0;

        fork
            begin repeat (150) rand_txn(0); end
            begin repeat (250) rand_txn(1); end
        join

        // Directed cases on the splitting instance
        run_txn(1, 1'b1, 3'b010, 32'h0100_0010, 32'hDEAD_BEEF, e);
        chk("sw strb", 32'(e.strb0), 32'h0000_000F);
        chk("sw addr", e.addr0, 32'h0100_0010);
        chk("sw naccess", 32'(e.nacc), 32'd1);
        run_txn(1, 1'b0, 3'b010, 32'h0100_0010, 32'h0, e);
        chk("lw rdata", e.rdata, 32'hDEAD_BEEF);
        run_txn(1, 1'b1, 3'b000, 32'h0100_0013, 32'h0000_00A5, e);
        chk("sb strb", 32'(e.strb0), 32'h0000_0008);
        chk("sb data", e.data0, 32'hA500_0000);
        run_txn(1, 1'b0, 3'b000, 32'h0100_0013, 32'h0, e);
        chk("lb rdata", e.rdata, 32'hFFFF_FFA5);
        run_txn(1, 1'b0, 3'b100, 32'h0100_0013, 32'h0, e);
        chk("lbu rdata", e.rdata, 32'h0000_00A5);
        run_txn(1, 1'b1, 3'b010, 32'h0100_0010, 32'h1122_3344, e);
        run_txn(1, 1'b1, 3'b010, 32'h0100_0014, 32'h5566_7788, e);
        run_txn(1, 1'b0, 3'b010, 32'h0100_0012, 32'h0, e);
        chk("split lw rdata", e.rdata, 32'h7788_1122);
        chk("split lw naccess", 32'(e.nacc), 32'd2);
        chk("split lw addr1", e.addr1, 32'h0100_0014);
        run_txn(1, 1'b1, 3'b001, 32'h0100_0013, 32'h0000_BEEF, e);
        chk("split sh strb0", 32'(e.strb0), 32'h0000_0008);
        chk("split sh strb1", 32'(e.strb1), 32'h0000_0001);
        chk("split sh data0", e.data0, 32'hEF00_0000);
        chk("split sh data1", e.data1, 32'h0000_00BE);
        run_txn(1, 1'b0, 3'b010, 32'h0000_0000, 32'h0, e);
        chk("oor lw err", 32'(e.err), 32'd1);
        chk("oor lw rdata", e.rdata, 32'h0);
        run_txn(1, 1'b0, 3'b011, 32'h0100_0010, 32'h0, e);
        chk("illegal f3 err", 32'(e.err), 32'd1);
        chk("illegal f3 naccess", 32'(e.nacc), 32'd0);
        run_txn(0, 1'b1, 3'b001, 32'h0100_0011, 32'h0000_BEEF, e);
        chk("no-split sh err", 32'(e.err), 32'd1);
        chk("no-split sh naccess", 32'(e.nacc), 32'd0);

        // Reset during the second access of a split load: no response may follow
        e = model(1, 1'b1, 1'b0, 3'b010, 32'h0100_0012, 32'h0);
        push_txn(1, e, 2);
        drive(1, 1'b1, 1'b0, 3'b010, 32'h0100_0012, 32'h0);
        step();
        drive(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (2) step();
        run_txn(1, 1'b0, 3'b010, 32'h0100_0010, 32'h0, e);
        chk("post-reset lw rdata", e.rdata, 32'hEF22_3344);

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
